mdu_unit: RTL and testbench
===========================

# mdu_unit

Multiply/divide unit for the execute stage of the 5-stage MIPS pipeline. It consumes the forwarded E-stage operands (forwarded rs/rt values after the M/W bypass selection) and holds the architectural HI/LO registers. Multiply and divide run for a fixed multi-cycle latency, and `busy` tells the hazard unit to stall MDU-dependent instructions in D. It serves mult, multu, div, divu, mthi, mtlo, mfhi and mflo.

## Interface
- `MULT_CYCLES`, default 5: busy duration for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy duration for div/divu (≥1).

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `op_valid`, input, 1: the E-stage instruction is a real MDU request, not a bubble.
- `mdu_op`, input, 3: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- `rs_val`, input, 32: forwarded rs operand.
- `rt_val`, input, 32: forwarded rt operand.
- `rd_sel`, input, 1: 0 selects LO, 1 selects HI for mfhi/mflo.
- `busy`, output, 1: a multiply/divide is in flight.
- `hi`, output, 32: architectural HI.
- `lo`, output, 32: architectural LO.
- `mdu_rd`, output, 32: combinational `rd_sel ? hi : lo`, sent to the E-stage result mux.

## Operation
- **Accept condition.** A request is accepted on an edge when `op_valid=1`, `mdu_op` is 1–6, and `busy=0`.
- **Requests while busy.** Any request while `busy=1` is ignored: no state change. The hazard unit must never issue one; the verification bench checks that it is ignored.
- **Arithmetic ops (MULT/MULTU/DIV/DIVU).** On acceptance:
  - latch `rs_val`/`rt_val` and the op;
  - load the cycle counter with MULT_CYCLES or DIV_CYCLES;
  - set `busy`;
  - the result is computed into internal shadow registers;
  - `hi`/`lo` are not changed until completion.
- **MULT.** Signed 32×32→64. `hi` = bits 63:32, `lo` = bits 31:0.
- **MULTU.** Unsigned 32×32→64, same split.
- **DIV.** Signed. `lo` = quotient, truncated toward zero. `hi` = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- **DIVU.** Unsigned. `lo` = quotient, `hi` = remainder.
- **Divide by zero (`rt_val`=0, DIV or DIVU).** Full busy period, but `hi`/`lo` are left unchanged at completion.
- **MTHI / MTLO.** Write `rs_val` to `hi` / `lo` on the accepting edge. No busy period.
- **MFHI / MFLO.** Not requests (`mdu_op`=0). `mdu_rd` reflects the current `hi`/`lo` combinationally. The hazard unit stalls mf* while `busy`.
- **States.**
  - IDLE: `busy`=0.
  - RUN: counter > 0.
  - IDLE→RUN on accepting a mult/div.
  - RUN decrements the counter each edge.
  - On the edge where the counter goes 1→0: `busy` clears, shadow results commit to `hi`/`lo`, and the unit returns to IDLE.
- **Counter width.** Wide enough for max(MULT_CYCLES, DIV_CYCLES). No wrap-around is possible.

## Timing
- **Reset values.** `rst_n` low (asynchronous) sets `hi`=0, `lo`=0, `busy`=0, counter=0, state IDLE, shadow registers=0.
- **Reset during RUN.** Aborts the operation; no commit on release.
- **Accept edge t (mult/div).** `busy`=1 from just after edge t through edge t+N, where N = MULT_CYCLES or DIV_CYCLES.
- **Commit.** `hi`/`lo` hold the new value right after edge t+N, in the same edge where `busy` falls.
- **Back-to-back.** A new request presented in the cycle after `busy` falls is accepted. The earliest back-to-back accept is edge t+N+1.
- **MTHI/MTLO accepted at edge t.** `hi`/`lo` hold the new value right after edge t.
- **Latency of `mdu_rd`.** Zero cycles: it reflects the registered value.
- **Operand changes.** Operands are sampled only on the accept edge. Changes to `rs_val`/`rt_val` while `busy` have no effect.

## Test plan
- **Signed multiply.** Reset, then MULT with rs=0xFFFFFFFD (−3), rt=5. Require:
  - `busy` high for exactly 5 cycles;
  - after the fall, `hi`=0xFFFFFFFF and `lo`=0xFFFFFFF1;
  - `hi`/`lo` stay 0 while busy.
- **Unsigned multiply, then read.** MULTU with 0xFFFFFFFF × 2. Require `hi`=0x00000001 and `lo`=0xFFFFFFFE. Then `rd_sel`=1 gives `mdu_rd`=0x00000001.
- **Signed divide.** DIV with −7 / 2. Require:
  - `busy` high for 10 cycles;
  - `lo`=0xFFFFFFFD and `hi`=0xFFFFFFFF.
  - Then DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000 and `hi`=0.
- **Divide by zero, then moves.** Pre-load via MTHI 0x1234 and MTLO 0x5678. Check each is visible the cycle after its accept. Then DIVU 9/0: after 10 busy cycles, `hi`=0x1234 and `lo`=0x5678 are unchanged.
- **Requests while busy.** Start MULT 3×4. While busy, present MTLO 0xAAAA and DIVU 8/2. Both must be ignored. Final `lo`=12, `hi`=0. A MULT issued on the cycle after `busy` falls is accepted.
- **Reset mid-operation.** Assert `rst_n`=0 for one cycle mid-DIV, at counter=4. Require `busy`, `hi` and `lo` go 0 immediately, with no commit afterwards.

Source files
------------

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the MIPS execute stage: holds HI/LO, runs mult/div
// for a fixed latency and commits the result when the busy period ends.
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   input  logic [2:0]  mdu_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        rd_sel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_rd
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } op_e;

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   op_e              op;
   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      shadow_hi;
   logic [31:0]      shadow_lo;
   logic             shadow_commit;

   logic [63:0] prod_s, prod_u;
   logic        div_zero;
   logic [31:0] safe_rt, abs_rs, abs_rt;
   logic [31:0] quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;

   logic             start;
   logic             commit_en;
   logic [CNT_W-1:0] load_cnt;
   logic [31:0]      res_hi, res_lo;

   assign op = op_e'(mdu_op);

   assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   // Divide on magnitudes so 0x80000000 / -1 has a defined result; a zero
   // divisor is replaced by 1 only to keep the datapath X-free (never committed).
   assign div_zero = (rt_val == 32'd0);
   assign safe_rt  = div_zero ? 32'd1 : rt_val;
   assign abs_rs   = rs_val[31]  ? (~rs_val + 32'd1)  : rs_val;
   assign abs_rt   = safe_rt[31] ? (~safe_rt + 32'd1) : safe_rt;
   assign quo_u    = rs_val / safe_rt;
   assign rem_u    = rs_val % safe_rt;
   assign quo_m    = abs_rs / abs_rt;
   assign rem_m    = abs_rs % abs_rt;
   assign quo_s    = (rs_val[31] ^ safe_rt[31]) ? (~quo_m + 32'd1) : quo_m;
   assign rem_s    = rs_val[31] ? (~rem_m + 32'd1) : rem_m;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      start     = 1'b0;
      commit_en = 1'b1;
      load_cnt  = '0;
      res_hi    = '0;
      res_lo    = '0;
      case (op)
         OP_MULT:  begin start = op_valid; load_cnt = CNT_W'(MULT_CYCLES); {res_hi, res_lo} = prod_s; end
         OP_MULTU: begin start = op_valid; load_cnt = CNT_W'(MULT_CYCLES); {res_hi, res_lo} = prod_u; end
         OP_DIV:   begin
            start = op_valid; load_cnt = CNT_W'(DIV_CYCLES);
            res_hi = rem_s; res_lo = quo_s; commit_en = ~div_zero;
         end
         OP_DIVU:  begin
            start = op_valid; load_cnt = CNT_W'(DIV_CYCLES);
            res_hi = rem_u; res_lo = quo_u; commit_en = ~div_zero;
         end
         default:  ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         busy          <= 1'b0;
         hi            <= '0;
         lo            <= '0;
         shadow_hi     <= '0;
         shadow_lo     <= '0;
         shadow_commit <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  shadow_hi     <= res_hi;
                  shadow_lo     <= res_lo;
                  shadow_commit <= commit_en;
                  cnt           <= load_cnt;
                  busy          <= 1'b1;
                  state         <= ST_RUN;
               end else if (op_valid && op == OP_MTHI) begin
                  hi <= rs_val;
               end else if (op_valid && op == OP_MTLO) begin
                  lo <= rs_val;
               end
            end
            ST_RUN: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                  if (shadow_commit) begin
                     hi <= shadow_hi;
                     lo <= shadow_lo;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mdu_rd = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: multiply, divide, moves, divide-by-zero,
// ignored requests while busy, and reset during an operation.
module tb_mdu_unit;

   logic        clk;
   logic        rst_n;
   logic        op_valid;
   logic [2:0]  mdu_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        rd_sel;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mdu_rd;

   int total = 0;
   int bad   = 0;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_valid (op_valid),
      .mdu_op   (mdu_op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .rd_sel   (rd_sel),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo),
      .mdu_rd   (mdu_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one request for a single edge; returns 1 ns after that edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op_valid = 1'b1;
      mdu_op   = op;
      rs_val   = a;
      rt_val   = b;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      mdu_op   = 3'd0;
   endtask

   // Counts edges until busy falls (bounded).
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; op_valid = 1'b0; mdu_op = 3'd0;
      rs_val = '0; rt_val = '0; rd_sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
      total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
      total++; if (mdu_rd !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h want=0", mdu_rd); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_signed_mult;
      int n;
      int leaks;
      leaks = 0;
      issue(3'd1, 32'hFFFF_FFFD, 32'd5);
      n = 0;
      while (busy && n < 50) begin
         if (hi !== 32'd0 || lo !== 32'd0) leaks++;
         @(posedge clk);
         #1;
         n++;
      end
      total++; if (n !== 5) begin bad++; $display("FAIL mult_busy_cycles got=%0d want=5", n); end
      total++; if (leaks !== 0) begin bad++; $display("FAIL mult_early_commit got=%0d want=0", leaks); end
      total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
      total++; if (lo !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo got=%h want=fffffff1", lo); end
   endtask

   task automatic test_unsigned_mult;
      int n;
      issue(3'd2, 32'hFFFF_FFFF, 32'd2);
      wait_idle(n);
      total++; if (n !== 5) begin bad++; $display("FAIL multu_busy_cycles got=%0d want=5", n); end
      total++; if (hi !== 32'h0000_0001) begin bad++; $display("FAIL multu_hi got=%h want=00000001", hi); end
      total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo got=%h want=fffffffe", lo); end
      rd_sel = 1'b1;
      #1;
      total++; if (mdu_rd !== 32'h0000_0001) begin bad++; $display("FAIL mfhi_rd got=%h want=00000001", mdu_rd); end
      rd_sel = 1'b0;
      #1;
      total++; if (mdu_rd !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mflo_rd got=%h want=fffffffe", mdu_rd); end
   endtask

   task automatic test_signed_div;
      int n;
      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      total++; if (n !== 10) begin bad++; $display("FAIL div_busy_cycles got=%0d want=10", n); end
      total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", lo); end
      total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", hi); end
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL div_min_lo got=%h want=80000000", lo); end
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL div_min_hi got=%h want=00000000", hi); end
      issue(3'd4, 32'd100, 32'd7);
      wait_idle(n);
      total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_result got=%h_%h want=00000002_0000000e", hi, lo); end
   endtask

   task automatic test_div_zero;
      int n;
      issue(3'd5, 32'h0000_1234, 32'd0);
      total++; if (hi !== 32'h0000_1234) begin bad++; $display("FAIL mthi got=%h want=00001234", hi); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b want=0", busy); end
      issue(3'd6, 32'h0000_5678, 32'd0);
      total++; if (lo !== 32'h0000_5678) begin bad++; $display("FAIL mtlo got=%h want=00005678", lo); end
      issue(3'd4, 32'd9, 32'd0);
      wait_idle(n);
      total++; if (n !== 10) begin bad++; $display("FAIL divz_busy_cycles got=%0d want=10", n); end
      total++; if (hi !== 32'h0000_1234) begin bad++; $display("FAIL divz_hi got=%h want=00001234", hi); end
      total++; if (lo !== 32'h0000_5678) begin bad++; $display("FAIL divz_lo got=%h want=00005678", lo); end
   endtask

   task automatic test_reserved;
      issue(3'd7, 32'hDEAD_BEEF, 32'd3);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rsvd_busy got=%b want=0", busy); end
      @(negedge clk);
      op_valid = 1'b0; mdu_op = 3'd1; rs_val = 32'd2; rt_val = 32'd2;
      @(posedge clk);
      #1;
      mdu_op = 3'd0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bubble_busy got=%b want=0", busy); end
      total++; if ({hi, lo} !== {32'h0000_1234, 32'h0000_5678}) begin bad++; $display("FAIL rsvd_state got=%h_%h want=00001234_00005678", hi, lo); end
   endtask

   task automatic test_back_to_back;
      int n;
      issue(3'd1, 32'd3, 32'd4);
      issue(3'd6, 32'h0000_AAAA, 32'd0);
      total++; if (lo !== 32'h0000_5678) begin bad++; $display("FAIL busy_mtlo_ignored got=%h want=00005678", lo); end
      issue(3'd4, 32'd8, 32'd2);
      rs_val = 32'd100; rt_val = 32'd100;
      wait_idle(n);
      total++; if (n !== 3) begin bad++; $display("FAIL busy_remaining got=%0d want=3", n); end
      total++; if (lo !== 32'd12) begin bad++; $display("FAIL busy_final_lo got=%h want=0000000c", lo); end
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL busy_final_hi got=%h want=00000000", hi); end
      issue(3'd1, 32'd6, 32'd7);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
      wait_idle(n);
      total++; if (n !== 5) begin bad++; $display("FAIL b2b_busy_cycles got=%0d want=5", n); end
      total++; if ({hi, lo} !== {32'd0, 32'd42}) begin bad++; $display("FAIL b2b_result got=%h_%h want=00000000_0000002a", hi, lo); end
   endtask

   task automatic test_reset_mid;
      int late;
      late = 0;
      issue(3'd3, 32'd100, 32'd7);
      repeat (6) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL rst_mid_hi got=%h want=0", hi); end
      total++; if (lo !== 32'd0) begin bad++; $display("FAIL rst_mid_lo got=%h want=0", lo); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) late++;
      end
      total++; if (late !== 0) begin bad++; $display("FAIL rst_no_commit got=%0d want=0", late); end
   endtask

   initial begin
      test_reset;
      test_signed_mult;
      test_unsigned_mult;
      test_signed_div;
      test_div_zero;
      test_reserved;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
